// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: decoded ID operands and pipeline controls in, stall/issue/forward selects out.
// The master drives the ID side; the scoreboard is the slave.
interface hazard_scoreboard_if #(
   parameter int SELW = 2
);
   logic            id_valid;
   logic [4:0]      id_rs1;
   logic [4:0]      id_rs2;
   logic            id_uses_rs1;
   logic            id_uses_rs2;
   logic [4:0]      id_rd;
   logic            id_writes_rd;
   logic [1:0]      id_lat_class;
   logic            pipe_hold;
   logic            flush;
   logic            stall;
   logic            issue;
   logic [SELW-1:0] fwd_sel_rs1;
   logic [SELW-1:0] fwd_sel_rs2;

   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
      output id_rd, id_writes_rd, id_lat_class, pipe_hold, flush,
      input  stall, issue, fwd_sel_rs1, fwd_sel_rs2
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
      input  id_rd, id_writes_rd, id_lat_class, pipe_hold, flush,
      output stall, issue, fwd_sel_rs1, fwd_sel_rs2
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight destination registers with per-class forwarding readiness.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles / issue_count performance counters.
module hazard_scoreboard #(
   parameter int NUM_STAGES       = 3,
   parameter int ALU_READY_STAGE  = 0,
   parameter int LOAD_READY_STAGE = 1,
   parameter int MUL_READY_STAGE  = 2,
   parameter int SELW             = $clog2(NUM_STAGES + 1)
) (
   input logic           clk,
   input logic           rst,
   hazard_scoreboard_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]   stall_cycles,
   output logic [31:0]   issue_count
`endif
);

   typedef struct packed {
      logic            nrdy;
      logic [SELW-1:0] sel;
   } match_t;

   logic [NUM_STAGES-1:0]           valid_q, valid_d;
   logic [NUM_STAGES-1:0][4:0]      rd_q, rd_d;
   logic [NUM_STAGES-1:0][SELW-1:0] rdy_q, rdy_d;

   match_t m_rs1, m_rs2;
   logic   stall, issue, new_valid;

   function automatic logic [SELW-1:0] class_rdy(input logic [1:0] cls);
      case (cls)
         2'd0:    return SELW'(ALU_READY_STAGE);
         2'd1:    return SELW'(LOAD_READY_STAGE);
         2'd2:    return SELW'(MUL_READY_STAGE);
         default: return SELW'(NUM_STAGES - 1);
      endcase
   endfunction

   // The youngest producer (lowest stage) decides, even if an older one is ready.
   function automatic match_t lookup(
      input logic [4:0]                  rs,
      input logic                        use_rs,
      input logic [NUM_STAGES-1:0]       v,
      input logic [NUM_STAGES-1:0][4:0]  rd,
      input logic [NUM_STAGES-1:0][SELW-1:0] rdy
   );
      match_t m;
      logic   hit;
      m   = '0;
      hit = 1'b0;
      if (use_rs && rs != 5'd0) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            if (!hit && v[k] && rd[k] == rs) begin
               hit = 1'b1;
               if (SELW'(k) >= rdy[k]) m.sel  = SELW'(k + 1);
               else                    m.nrdy = 1'b1;
            end
         end
      end
      return m;
   endfunction

   always_comb begin
      m_rs1     = lookup(hz.id_rs1, hz.id_uses_rs1, valid_q, rd_q, rdy_q);
      m_rs2     = lookup(hz.id_rs2, hz.id_uses_rs2, valid_q, rd_q, rdy_q);
      stall     = hz.id_valid & (m_rs1.nrdy | m_rs2.nrdy);
      issue     = hz.id_valid & ~stall & ~hz.flush & ~hz.pipe_hold;
      new_valid = issue & hz.id_writes_rd & (hz.id_rd != 5'd0);
   end

   assign hz.stall       = stall;
   assign hz.issue       = issue;
   assign hz.fwd_sel_rs1 = m_rs1.sel;
   assign hz.fwd_sel_rs2 = m_rs2.sel;

   always_comb begin
      valid_d = valid_q;
      rd_d    = rd_q;
      rdy_d   = rdy_q;
      if (!hz.pipe_hold) begin
         valid_d = {valid_q[NUM_STAGES-2:0], new_valid};
         rd_d    = {rd_q[NUM_STAGES-2:0], hz.id_rd};
         rdy_d   = {rdy_q[NUM_STAGES-2:0], class_rdy(hz.id_lat_class)};
      end
   end

   // Stage boundary: ID -> stage 0, stage k -> stage k+1
   always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else     valid_q <= valid_d;
      rd_q  <= rd_d;
      rdy_q <= rdy_d;
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] issue_count_q, issue_count_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q + {31'd0, stall & ~hz.pipe_hold & ~hz.flush};
      issue_count_d  = issue_count_q + {31'd0, issue};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
         issue_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         issue_count_q  <= issue_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign issue_count  = issue_count_q;
`endif

endmodule
